// File: rtl/sine_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sine_pkg                                                         |
// | Purpose  : Shared widths, the midscale constant, the quadrant enum and the  |
// |            pipeline tag type used by the sine sequencer.                    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sine_pkg;

   localparam int unsigned QW_ADDR_W = 7;
   localparam int unsigned SAMPLE_W  = 10;
   localparam int unsigned PHASE_W   = 9;
   localparam logic [SAMPLE_W-1:0] MIDSCALE = 10'd512;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quadrant_t;

   typedef struct packed {
      logic      valid;
      quadrant_t quadrant;
   } stage_tag_t;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tick_gen                                                         |
// | Purpose  : Clock divider producing one phase-step tick every DIV enabled    |
// |            clocks. The divider freezes while enable is low.                 |
// | Ports    : clk, rst (sync, active high), enable -> tick (combinational)     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_divider;

   assign tick = enable && (r_divider == C_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_divider <= '0;
      end else if (tick) begin
         r_divider <= '0;
      end else if (enable) begin
         r_divider <= r_divider + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sine_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sine_sequencer                                                   |
// | Purpose  : Walks a 9-bit phase accumulator, addresses a quarter-wave ROM    |
// |            with quadrant mirroring and rebuilds full-wave samples with      |
// |            quadrant inversion for the DAC/PWM stage.                        |
// | Ports    : clk, rst, enable        - clock, sync reset, run control         |
// |            read_address / read_data - ROM interface (1-cycle read)          |
// |            sample, sample_valid,    - reconstructed sample, new-value pulse |
// |            quadrant                   and its quadrant tag                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sine_sequencer
   import sine_pkg::*;
#(
   parameter int unsigned DIV        = 4,
   parameter int unsigned PHASE_STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   output logic [QW_ADDR_W-1:0] read_address,
   input  logic [SAMPLE_W-1:0]  read_data,
   output logic [SAMPLE_W-1:0]  sample,
   output logic                 sample_valid,
   output logic [1:0]           quadrant
);

   logic               w_tick;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] w_phase_next;
   stage_tag_t         r_stage0;
   stage_tag_t         r_stage1;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (w_tick)
   );

   // Natural 9-bit overflow gives the modulo-512 wrap.
   assign w_phase_next = r_phase + PHASE_W'(PHASE_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase      <= '0;
         read_address <= '0;
         r_stage0     <= '0;
         r_stage1     <= '0;
         sample       <= MIDSCALE;
         sample_valid <= 1'b0;
         quadrant     <= Q0;
      end else begin
         r_stage1     <= r_stage0;
         sample_valid <= r_stage1.valid;

         if (w_tick) begin
            r_phase <= w_phase_next;
            // Odd quadrants run the quarter-wave backwards (127 - index).
            read_address      <= w_phase_next[7] ? ~w_phase_next[6:0] : w_phase_next[6:0];
            r_stage0.valid    <= 1'b1;
            r_stage0.quadrant <= quadrant_t'(w_phase_next[8:7]);
         end else begin
            r_stage0.valid    <= 1'b0;
         end

         // read_data now belongs to the address issued with this tag.
         if (r_stage1.valid) begin
            // Lower half-wave: bitwise invert equals 1023 - x.
            sample   <= (r_stage1.quadrant inside {Q2, Q3}) ? ~read_data : read_data;
            quadrant <= r_stage1.quadrant;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sine_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sine_sequencer                                                |
// | Purpose  : Self-checking bench for sine_sequencer. Three instances:         |
// |            u0 DIV=1 STEP=1, u1 DIV=4 STEP=1, u2 DIV=1 STEP=5, each with a   |
// |            behavioural ROM and compared every cycle against a phase model.  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sine_sequencer;

   logic       clk;
   logic       rst;
   logic       en   [3];
   logic [6:0] ra   [3];
   logic [9:0] rd   [3];
   logic [9:0] smp  [3];
   logic       sv   [3];
   logic [1:0] qd   [3];

   int checks;
   int failures;
   bit chk_on;

   // ---------------- DUTs ----------------
   sine_sequencer #(.DIV(1), .PHASE_STEP(1)) u0 (
      .clk(clk), .rst(rst), .enable(en[0]), .read_address(ra[0]), .read_data(rd[0]),
      .sample(smp[0]), .sample_valid(sv[0]), .quadrant(qd[0]));
   sine_sequencer #(.DIV(4), .PHASE_STEP(1)) u1 (
      .clk(clk), .rst(rst), .enable(en[1]), .read_address(ra[1]), .read_data(rd[1]),
      .sample(smp[1]), .sample_valid(sv[1]), .quadrant(qd[1]));
   sine_sequencer #(.DIV(1), .PHASE_STEP(5)) u2 (
      .clk(clk), .rst(rst), .enable(en[2]), .read_address(ra[2]), .read_data(rd[2]),
      .sample(smp[2]), .sample_valid(sv[2]), .quadrant(qd[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Quarter-wave ROM contents: strictly increasing, 512..1023.
   function automatic int rom(input int a);
      return 512 + 4 * a + a / 32;
   endfunction

   function automatic int div_of(input int k);
      return (k == 1) ? 4 : 1;
   endfunction

   function automatic int step_of(input int k);
      return (k == 2) ? 5 : 1;
   endfunction

   // Behavioural ROMs with one-cycle registered read.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) rd[k] <= 10'(rom(int'(ra[k])));
   end

   task automatic chk(input string nm, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s u%0d t=%0t: got %0d expected %0d", nm, k, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_div   [3];
   int m_phase [3];
   int e_addr  [3];
   int e_smp   [3];
   int e_v     [3];
   int e_q     [3];
   bit p_v     [3][2];
   int p_s     [3][2];
   int p_q     [3][2];

   always @(posedge clk) begin : b_model
      bit tk;
      int q, idx, a;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_div[k] = 0;  m_phase[k] = 0; e_addr[k] = 0;
            e_smp[k] = 512; e_v[k] = 0;    e_q[k] = 0;
            p_v[k][0] = 1'b0; p_v[k][1] = 1'b0;
         end else begin
            tk = en[k] && (m_div[k] == div_of(k) - 1);
            // A step emits its sample two clocks after the step itself.
            e_v[k] = int'(p_v[k][1]);
            if (p_v[k][1]) begin
               e_smp[k] = p_s[k][1];
               e_q[k]   = p_q[k][1];
            end
            p_v[k][1] = p_v[k][0]; p_s[k][1] = p_s[k][0]; p_q[k][1] = p_q[k][0];
            p_v[k][0] = 1'b0;
            if (tk) begin
               m_div[k]   = 0;
               m_phase[k] = (m_phase[k] + step_of(k)) % 512;
               q   = m_phase[k] / 128;
               idx = m_phase[k] % 128;
               a   = (q % 2 == 1) ? 127 - idx : idx;
               e_addr[k] = a;
               p_v[k][0] = 1'b1;
               p_q[k][0] = q;
               p_s[k][0] = (q >= 2) ? 1023 - rom(a) : rom(a);
            end else if (en[k]) begin
               m_div[k] = m_div[k] + 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 3; k++) begin
            chk("addr",    k, int'(ra[k]),  e_addr[k]);
            chk("sample",  k, int'(smp[k]), e_smp[k]);
            chk("valid",   k, int'(sv[k]),  e_v[k]);
            chk("quadrant",k, int'(qd[k]),  e_q[k]);
         end
      end
   end

   // ---------------- bookkeeping for literal checks ----------------
   int cyc, pc0, pc1, pc2, pause_pulses;
   int hist0 [0:1023];
   int hist2 [0:1023];
   int p0_s  [0:1023];
   int p0_q  [0:1023];
   int p2_s  [0:1023];
   int p2_q  [0:1023];
   int p1_c  [0:3];
   int p1_s1;

   always @(negedge clk) begin
      if (rst) begin
         cyc = 0; pc0 = 0; pc1 = 0; pc2 = 0; pause_pulses = 0;
      end else begin
         cyc++;
         if (cyc < 1024) begin
            hist0[cyc] = int'(ra[0]);
            hist2[cyc] = int'(ra[2]);
         end
         if (sv[0]) begin
            pc0++;
            if (pc0 < 1024) begin
               p0_s[pc0] = int'(smp[0]);
               p0_q[pc0] = int'(qd[0]);
            end
            if (cyc >= 673 && cyc <= 682) pause_pulses++;
         end
         if (sv[1]) begin
            pc1++;
            if (pc1 <= 3) p1_c[pc1] = cyc;
            if (pc1 == 1) p1_s1 = int'(smp[1]);
         end
         if (sv[2]) begin
            pc2++;
            if (pc2 < 1024) begin
               p2_s[pc2] = int'(smp[2]);
               p2_q[pc2] = int'(qd[2]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks = 0; failures = 0; chk_on = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) en[k] = 1'b1;

      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_sample", k, int'(smp[k]), 512);
         chk("reset_addr",   k, int'(ra[k]),  0);
         chk("reset_valid",  k, int'(sv[k]),  0);
      end
      chk_on = 1'b1;
      #1 rst = 1'b0;

      // Run u0 into the middle of its second Q1 (phase 160), then pause it.
      repeat (672) @(negedge clk);
      #1 en[0] = 1'b0;
      repeat (10) @(negedge clk);
      #1 en[0] = 1'b1;
      repeat (20) @(negedge clk);

      // Hand-computed pins, u0 (DIV=1, STEP=1): pulse n carries phase n.
      chk("u0_first_sample", 0, p0_s[1],   516);
      chk("u0_first_quad",   0, p0_q[1],   0);
      chk("u0_addr_127",     0, hist0[127], 127);
      chk("u0_addr_128",     0, hist0[128], 127);
      chk("u0_addr_129",     0, hist0[129], 126);
      chk("u0_smp_127",      0, p0_s[127], 1023);
      chk("u0_smp_128",      0, p0_s[128], 1023);
      chk("u0_smp_256",      0, p0_s[256], 511);
      chk("u0_quad_256",     0, p0_q[256], 2);
      chk("u0_smp_384",      0, p0_s[384], 0);
      chk("u0_addr_511",     0, hist0[511], 0);
      chk("u0_smp_512",      0, p0_s[512], 512);
      chk("u0_quad_512",     0, p0_q[512], 0);
      // Pause: two in-flight pulses drain, address frozen, resume at phase 161.
      chk("u0_pause_pulses", 0, pause_pulses, 2);
      chk("u0_pause_addr",   0, hist0[682], 95);
      chk("u0_resume_addr",  0, hist0[683], 94);
      // u1 (DIV=4): first step at clock 4, first pulse at 6, then every 4.
      chk("u1_first_pulse",  1, p1_c[1], 6);
      chk("u1_interval",     1, p1_c[2] - p1_c[1], 4);
      chk("u1_interval2",    1, p1_c[3] - p1_c[2], 4);
      chk("u1_first_sample", 1, p1_s1, 516);
      // u2 (STEP=5): step 102 is phase 510, step 103 wraps to phase 3.
      chk("u2_addr_510",     2, hist2[102], 1);
      chk("u2_smp_510",      2, p2_s[102], 507);
      chk("u2_quad_510",     2, p2_q[102], 3);
      chk("u2_addr_wrap",    2, hist2[103], 3);
      chk("u2_smp_wrap",     2, p2_s[103], 524);
      chk("u2_quad_wrap",    2, p2_q[103], 0);

      // Reset one cycle after a step with the pipeline full.
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_sample",  0, int'(smp[0]), 512);
      chk("rst_valid",   0, int'(sv[0]),  0);
      chk("rst_addr",    0, int'(ra[0]),  0);
      chk("rst_quad",    0, int'(qd[0]),  0);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid1", 0, int'(sv[0]), 0);
      @(negedge clk);
      chk("post_rst_valid2", 0, int'(sv[0]), 0);
      @(negedge clk);
      chk("post_rst_valid3", 0, int'(sv[0]), 1);
      chk("post_rst_sample", 0, int'(smp[0]), 516);
      repeat (8) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
